// File: rtl/riscv_pkg.sv
// Shared core-wide constants and register-address types.
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the register file: reads, write, issue and flush.
interface regfile_sb_if import riscv_pkg::*; #(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) ();
    logic [NUM_RD*AW-1:0]     ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we;
    logic [AW-1:0]            wa;
    logic [DATA_W-1:0]        wd;
    logic                     wb_clr;
    logic                     iss_valid;
    logic [AW-1:0]            iss_rd;
    logic                     flush;
    logic [AW:0]              busy_cnt;

    modport slave (
        input  ra, we, wa, wd, wb_clr, iss_valid, iss_rd, flush,
        output rd, rd_busy, busy_cnt
    );

    modport master (
        output ra, we, wa, wd, wb_clr, iss_valid, iss_rd, flush,
        input  rd, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy bits with flush/issue/writeback priority, registered
// popcount and per-read-port RAW hazard lookup.
module regfile_sb_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RD*AW-1:0] i_ra,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_wa,
    input  logic                 i_wb_clr,
    input  logic                 i_iss_valid,
    input  logic [AW-1:0]        i_iss_rd,
    input  logic                 i_flush,
    output logic [NUM_RD-1:0]    o_rd_busy,
    output logic [AW:0]          o_busy_cnt
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [AW:0]         r_cnt;
    logic [AW:0]         w_cnt_nxt;

    // A new producer outranks a completing one on the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (i_flush)
                w_busy_nxt[r] = 1'b0;
            else if (i_iss_valid && i_iss_rd == AW'(r))
                w_busy_nxt[r] = 1'b1;
            else if (i_we && i_wb_clr && i_wa == AW'(r))
                w_busy_nxt[r] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++)
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_busy_cnt = r_cnt;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_haz
        logic [AW-1:0] w_ra;
        logic          w_fwd;
        assign w_ra  = i_ra[k*AW +: AW];
        // Completing writeback forwards its data, so no stall unless re-issued.
        assign w_fwd = (BYPASS != 0) && i_we && i_wb_clr && (i_wa == w_ra) &&
                       !(i_iss_valid && i_iss_rd == w_ra);
        assign o_rd_busy[k] = (w_ra == '0) ? 1'b0 :
                              w_fwd         ? 1'b0 : r_busy[w_ra];
    end
endmodule

// File: rtl/regfile_sb.sv
// Integer register file: combinational read ports, one write port, optional
// write-to-read bypass, and a busy scoreboard for RAW hazard detection.
module regfile_sb import riscv_pkg::*; #(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_regs <= '0;
        else if (bus.we && bus.wa != '0)
            r_regs[bus.wa] <= bus.wd;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] w_ra;
        assign w_ra = bus.ra[k*AW +: AW];
        assign bus.rd[k*DATA_W +: DATA_W] =
            (w_ra == '0)                                  ? '0      :
            ((BYPASS != 0) && bus.we && bus.wa == w_ra)   ? bus.wd  :
                                                            r_regs[w_ra];
    end

    regfile_sb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_ra        (bus.ra),
        .i_we        (bus.we),
        .i_wa        (bus.wa),
        .i_wb_clr    (bus.wb_clr),
        .i_iss_valid (bus.iss_valid),
        .i_iss_rd    (bus.iss_rd),
        .i_flush     (bus.flush),
        .o_rd_busy   (bus.rd_busy),
        .o_busy_cnt  (bus.busy_cnt)
    );
endmodule
